// File: rtl/pool_1_pkg.sv
// rtl/pool_1_pkg.sv - shared widths, FSM encoding and signed max helper for pool_1
package pool_1_pkg;

  localparam int LANES  = 56;
  localparam int DW     = 16;
  localparam int FM1_AW = 7;
  localparam int FM2_AW = 6;
  localparam int PAIR_W = FM1_AW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [DW-1:0] max_s(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_1_if.sv
// rtl/pool_1_if.sv - fm_bram_1 dual read ports and fm_bram_2 write port seen by pool_1
interface pool_1_if;
  import pool_1_pkg::*;

  logic                  fm_bram_1_ena;
  logic                  fm_bram_1_enb;
  logic [FM1_AW-1:0]     fm_bram_1_addra;
  logic [FM1_AW-1:0]     fm_bram_1_addrb;
  logic [LANES*DW-1:0]   fm_bram_1_douta;
  logic [LANES*DW-1:0]   fm_bram_1_doutb;
  logic                  fm_bram_2_we;
  logic [FM2_AW-1:0]     fm_bram_2_addr;
  logic [LANES*DW-1:0]   fm_bram_2_din;

  modport master (
    output fm_bram_1_ena, fm_bram_1_enb, fm_bram_1_addra, fm_bram_1_addrb,
    input  fm_bram_1_douta, fm_bram_1_doutb,
    output fm_bram_2_we, fm_bram_2_addr, fm_bram_2_din
  );

  modport slave (
    input  fm_bram_1_ena, fm_bram_1_enb, fm_bram_1_addra, fm_bram_1_addrb,
    output fm_bram_1_douta, fm_bram_1_doutb,
    input  fm_bram_2_we, fm_bram_2_addr, fm_bram_2_din
  );

endinterface

// File: rtl/pool_max2x2_lane.sv
// rtl/pool_max2x2_lane.sv - combinational 2x2 signed max for one pooled lane
// Vertical max feeds a register in pool_1; horizontal max plus ReLU works on the registered pair.
module pool_max2x2_lane
  import pool_1_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] v0,
  input  logic [DW-1:0] v1,
  output logic [DW-1:0] m0,
  output logic [DW-1:0] m1,
  output logic [DW-1:0] p
);

  logic [DW-1:0] h;

  assign m0 = max_s(a0, b0);
  assign m1 = max_s(a1, b1);
  assign h  = max_s(v0, v1);
  assign p  = (RELU_EN && h[DW-1]) ? '0 : h;

endmodule

// File: rtl/pool_1.sv
// rtl/pool_1.sv - 2x2 max pool (+ReLU) from fm_bram_1 row pairs into packed fm_bram_2 words
module pool_1
  import pool_1_pkg::*;
#(
  parameter int NUM_WORDS = 84,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pool_1_en,
  pool_1_if.master  bram,
  output logic      busy,
  output logic      pool_1_finish
);

  localparam int                HL     = LANES / 2;
  localparam int                NP     = NUM_WORDS / 2;
  localparam logic [PAIR_W-1:0] LAST_K = PAIR_W'(NP - 1);
  localparam bit                ODD_NP = (NP % 2) == 1;

  state_t              state, state_nx;
  logic [PAIR_W-1:0]   k, k_nx;
  logic [1:0]          drain_cnt, drain_nx;
  logic                en_d, en_d2, start, abort, rd_on;
  logic                rd_vld, v_vld, p_vld;
  logic [PAIR_W-1:0]   rd_k, v_k, p_k;
  logic [LANES*DW-1:0] v_q, v_nx;
  logic [HL*DW-1:0]    p_q, p_nx, lo_q;

  assign start = en_d & ~en_d2;
  assign abort = ((state == READ) || (state == DRAIN)) && !pool_1_en;
  assign rd_on = (state == READ);

  assign bram.fm_bram_1_ena   = rd_on;
  assign bram.fm_bram_1_enb   = rd_on;
  assign bram.fm_bram_1_addra = rd_on ? {k, 1'b0} : '0;
  assign bram.fm_bram_1_addrb = rd_on ? {k, 1'b1} : '0;

  always_comb begin
    state_nx = state;
    k_nx     = k;
    drain_nx = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = READ;
          k_nx     = '0;
        end
      end
      READ: begin
        if (!pool_1_en) begin
          state_nx = IDLE;
        end else if (k == LAST_K) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      DRAIN: begin
        if (!pool_1_en) begin
          state_nx = IDLE;
        end else if (drain_cnt == 2'd2) begin
          state_nx = DONE;
        end else begin
          drain_nx = drain_cnt + 1'b1;
        end
      end
      DONE: begin
        if (!pool_1_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar j = 0; j < HL; j++) begin : g_lane
    pool_max2x2_lane #(.RELU_EN(RELU_EN)) u_lane (
      .a0 (bram.fm_bram_1_douta[(2*j)*DW +: DW]),
      .b0 (bram.fm_bram_1_doutb[(2*j)*DW +: DW]),
      .a1 (bram.fm_bram_1_douta[(2*j+1)*DW +: DW]),
      .b1 (bram.fm_bram_1_doutb[(2*j+1)*DW +: DW]),
      .v0 (v_q[(2*j)*DW +: DW]),
      .v1 (v_q[(2*j+1)*DW +: DW]),
      .m0 (v_nx[(2*j)*DW +: DW]),
      .m1 (v_nx[(2*j+1)*DW +: DW]),
      .p  (p_nx[j*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      k                    <= '0;
      drain_cnt            <= '0;
      en_d                 <= 1'b0;
      en_d2                <= 1'b0;
      rd_vld               <= 1'b0;
      v_vld                <= 1'b0;
      p_vld                <= 1'b0;
      rd_k                 <= '0;
      v_k                  <= '0;
      p_k                  <= '0;
      v_q                  <= '0;
      p_q                  <= '0;
      lo_q                 <= '0;
      bram.fm_bram_2_we    <= 1'b0;
      bram.fm_bram_2_addr  <= '0;
      bram.fm_bram_2_din   <= '0;
      busy                 <= 1'b0;
      pool_1_finish        <= 1'b0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      drain_cnt <= drain_nx;
      en_d      <= pool_1_en;
      en_d2     <= en_d;
      v_q       <= v_nx;
      p_q       <= p_nx;
      // busy covers the first DONE cycle so it hands over directly to finish
      busy          <= (state_nx == READ) || (state_nx == DRAIN) ||
                       ((state == DRAIN) && (state_nx == DONE));
      pool_1_finish <= (state == DONE) && (state_nx == DONE);

      if (abort) begin
        rd_vld            <= 1'b0;
        v_vld             <= 1'b0;
        p_vld             <= 1'b0;
        bram.fm_bram_2_we <= 1'b0;
      end else begin
        rd_vld            <= rd_on;
        rd_k              <= k;
        v_vld             <= rd_vld;
        v_k               <= rd_k;
        p_vld             <= v_vld;
        p_k               <= v_k;
        bram.fm_bram_2_we <= 1'b0;
        if (p_vld) begin
          if (!p_k[0]) begin
            lo_q <= p_q;
            if (ODD_NP && (p_k == LAST_K)) begin
              bram.fm_bram_2_we   <= 1'b1;
              bram.fm_bram_2_addr <= FM2_AW'(p_k >> 1);
              bram.fm_bram_2_din  <= {{(HL*DW){1'b0}}, p_q};
            end
          end else begin
            bram.fm_bram_2_we   <= 1'b1;
            bram.fm_bram_2_addr <= FM2_AW'(p_k >> 1);
            bram.fm_bram_2_din  <= {p_q, lo_q};
          end
        end
      end

      if ((state == IDLE) && start) bram.fm_bram_2_addr <= '0;
    end
  end

endmodule

// File: tb/tb_pool_1.sv
// tb/tb_pool_1.sv - scoreboard bench for pool_1 (84-word ReLU instance and 6-word linear instance)
`timescale 1ns/1ps
module tb_pool_1;
  import pool_1_pkg::*;

  localparam int W   = LANES * DW;
  localparam int HL  = LANES / 2;
  localparam int HW  = HL * DW;
  localparam int NW0 = 84;
  localparam int NW1 = 6;

  typedef struct packed {
    logic [FM2_AW-1:0] addr;
    logic [W-1:0]      din;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic busy0, busy1, fin0, fin1;
  int   cyc = 0;
  int   checks = 0, errors = 0, mchecks = 0, merrors = 0;

  logic [W-1:0] mem0 [NW0];
  logic [W-1:0] mem1 [NW1];
  wr_t          exp0[$];
  wr_t          exp1[$];
  logic [W-1:0] wlog0[$];
  logic [W-1:0] wlog1[$];

  pool_1_if bif0();
  pool_1_if bif1();

  pool_1 #(.NUM_WORDS(NW0), .RELU_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .pool_1_en(en0), .bram(bif0.master),
    .busy(busy0), .pool_1_finish(fin0)
  );

  pool_1 #(.NUM_WORDS(NW1), .RELU_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .pool_1_en(en1), .bram(bif1.master),
    .busy(busy1), .pool_1_finish(fin1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bif0.fm_bram_1_ena) bif0.fm_bram_1_douta <= mem0[int'(bif0.fm_bram_1_addra)];
    if (bif0.fm_bram_1_enb) bif0.fm_bram_1_doutb <= mem0[int'(bif0.fm_bram_1_addrb)];
    if (bif1.fm_bram_1_ena) bif1.fm_bram_1_douta <= mem1[int'(bif1.fm_bram_1_addra)];
    if (bif1.fm_bram_1_enb) bif1.fm_bram_1_doutb <= mem1[int'(bif1.fm_bram_1_addrb)];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] word(input int d, input int i);
    if (d != 0) return mem1[i];
    return mem0[i];
  endfunction

  // Reference: each output lane is the signed maximum of a 2x2 window across two rows
  function automatic logic [HW-1:0] pool_pair(input logic [W-1:0] e, input logic [W-1:0] o,
                                             input bit relu);
    logic [HW-1:0] r;
    logic [DW-1:0] x;
    int m, c;
    r = '0;
    for (int j = 0; j < HL; j++) begin
      m = -(1 << 20);
      for (int q = 0; q < 4; q++) begin
        x = (q < 2) ? e[(2*j + q%2)*DW +: DW] : o[(2*j + q%2)*DW +: DW];
        c = int'($signed(x));
        if (c > m) m = c;
      end
      if (relu && m < 0) m = 0;
      r[j*DW +: DW] = m[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic get_ena(input int d);
    return (d != 0) ? bif1.fm_bram_1_ena : bif0.fm_bram_1_ena;
  endfunction
  function automatic logic [FM1_AW-1:0] get_addra(input int d);
    return (d != 0) ? bif1.fm_bram_1_addra : bif0.fm_bram_1_addra;
  endfunction
  function automatic logic [FM1_AW-1:0] get_addrb(input int d);
    return (d != 0) ? bif1.fm_bram_1_addrb : bif0.fm_bram_1_addrb;
  endfunction
  function automatic logic get_fin(input int d);
    return (d != 0) ? fin1 : fin0;
  endfunction
  function automatic logic get_busy(input int d);
    return (d != 0) ? busy1 : busy0;
  endfunction

  task automatic set_en(input int d, input logic v);
    if (d != 0) en1 = v; else en0 = v;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic mon_write(input int d, input logic [FM2_AW-1:0] a, input logic [W-1:0] din);
    wr_t e;
    int  bad;
    if (d != 0) wlog1.push_back(din); else wlog0.push_back(din);
    mchecks++;
    if ((d == 0 && exp0.size() == 0) || (d != 0 && exp1.size() == 0)) begin
      merrors++;
      $display("FAIL unexpected_write dut%0d: got write to addr %0d expected none", d, a);
      return;
    end
    if (d != 0) e = exp1.pop_front(); else e = exp0.pop_front();
    if (a !== e.addr) begin
      merrors++;
      $display("FAIL write_addr dut%0d: got %0d expected %0d", d, a, e.addr);
    end
    mchecks++;
    bad = -1;
    for (int l = 0; l < LANES; l++)
      if (bad < 0 && din[l*DW +: DW] !== e.din[l*DW +: DW]) bad = l;
    if (bad >= 0) begin
      merrors++;
      $display("FAIL write_din dut%0d addr %0d lane %0d: got %04h expected %04h",
               d, e.addr, bad, din[bad*DW +: DW], e.din[bad*DW +: DW]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bif0.fm_bram_2_we) mon_write(0, bif0.fm_bram_2_addr, bif0.fm_bram_2_din);
      if (bif1.fm_bram_2_we) mon_write(1, bif1.fm_bram_2_addr, bif1.fm_bram_2_din);
    end
  end

  // pat: 0 random (with 0x8000 seeded), 1 ramp, 2 all -5, 3 signed-compare corner
  task automatic fill(input int d, input int pat);
    int nw;
    logic [W-1:0]  w;
    logic [DW-1:0] v;
    nw = (d != 0) ? NW1 : NW0;
    for (int i = 0; i < nw; i++) begin
      for (int l = 0; l < LANES; l++) begin
        case (pat)
          0:       v = ($urandom_range(0, 7) == 0) ? 16'h8000 : DW'($urandom);
          1:       v = DW'((i / 2) * 100 + l + (i % 2) * 50);
          2:       v = 16'hFFFB;
          default: begin
            v = 16'h0000;
            if (i == 0 && l == 0) v = 16'h8000;
            if (i == 1 && l == 0) v = 16'h0001;
            if (i < 2 && l == 1)  v = 16'hFFFF;
          end
        endcase
        w[l*DW +: DW] = v;
      end
      if (d != 0) mem1[i] = w; else mem0[i] = w;
    end
  endtask

  task automatic push_exp(input int d);
    int  np;
    bit  relu;
    wr_t e;
    np   = ((d != 0) ? NW1 : NW0) / 2;
    relu = (d == 0);
    for (int a = 0; 2 * a < np; a++) begin
      e.addr          = FM2_AW'(a);
      e.din[HW-1:0]   = pool_pair(word(d, 4*a), word(d, 4*a + 1), relu);
      e.din[W-1:HW]   = (2*a + 1 < np) ? pool_pair(word(d, 4*a + 2), word(d, 4*a + 3), relu) : '0;
      if (d != 0) exp1.push_back(e); else exp0.push_back(e);
    end
  endtask

  task automatic run_pass(input int d, input int pat, output int base);
    int np, nwr, sc, qs, ws;
    bit seen;
    np  = ((d != 0) ? NW1 : NW0) / 2;
    nwr = (np + 1) / 2;
    fill(d, pat);
    push_exp(d);
    base = (d != 0) ? wlog1.size() : wlog0.size();
    @(negedge clk);
    set_en(d, 1'b1);
    sc   = cyc + 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = get_ena(d);
    end
    chk("first_read_seen", 64'(seen), 1);
    chk("first_read_latency", 64'(cyc - sc), 1);
    chk("first_addra", 64'(get_addra(d)), 0);
    chk("first_addrb", 64'(get_addrb(d)), 1);
    chk("busy_in_read", 64'(get_busy(d)), 1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = get_fin(d);
    end
    chk("finish_seen", 64'(seen), 1);
    chk("finish_latency", 64'(cyc - sc), 64'(np + 5));
    chk("busy_at_finish", 64'(get_busy(d)), 0);
    qs = (d != 0) ? exp1.size() : exp0.size();
    ws = ((d != 0) ? wlog1.size() : wlog0.size()) - base;
    chk("scoreboard_drained", 64'(qs), 0);
    chk("write_count", 64'(ws), 64'(nwr));
    set_en(d, 1'b0);
    repeat (2) @(negedge clk);
    chk("finish_cleared", 64'(get_fin(d)), 0);
  endtask

  initial begin
    int b, wc, nz;
    bit seen;
    logic [W-1:0] lw;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ena", 64'(bif0.fm_bram_1_ena), 0);
    chk("rst_enb", 64'(bif0.fm_bram_1_enb), 0);
    chk("rst_addra", 64'(bif0.fm_bram_1_addra), 0);
    chk("rst_addrb", 64'(bif0.fm_bram_1_addrb), 0);
    chk("rst_we", 64'(bif0.fm_bram_2_we), 0);
    chk("rst_waddr", 64'(bif0.fm_bram_2_addr), 0);
    chk("rst_din_zero", 64'(bif0.fm_bram_2_din == '0), 1);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_finish", 64'(fin0), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset while reading pair 10
    fill(0, 0);
    push_exp(0);
    @(negedge clk);
    en0  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bif0.fm_bram_1_ena && (bif0.fm_bram_1_addra == 7'd20);
    end
    chk("reach_k10", 64'(seen), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ena", 64'(bif0.fm_bram_1_ena), 0);
    chk("arst_addrb", 64'(bif0.fm_bram_1_addrb), 0);
    chk("arst_we", 64'(bif0.fm_bram_2_we), 0);
    chk("arst_waddr", 64'(bif0.fm_bram_2_addr), 0);
    chk("arst_busy", 64'(busy0), 0);
    exp0.delete();
    en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ramp pattern with hand-derived lanes
    run_pass(0, 1, b);
    lw = wlog0[b];
    for (int j = 0; j < HL; j++) begin
      chk("ramp_lo_lane", 64'(lw[j*DW +: DW]), 64'(2*j + 51));
      chk("ramp_hi_lane", 64'(lw[(HL + j)*DW +: DW]), 64'(2*j + 151));
    end

    run_pass(0, 2, b);
    nz = 0;
    for (int i = 0; i < 21; i++) if (wlog0[b + i] != '0) nz++;
    chk("relu_all_zero_words", 64'(nz), 0);

    run_pass(0, 3, b);
    lw = wlog0[b];
    chk("signed_lane0", 64'(lw[DW-1:0]), 64'h0001);

    run_pass(0, 0, b);

    // abort while reading pair 5
    fill(0, 0);
    push_exp(0);
    b = wlog0.size();
    @(negedge clk);
    en0  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bif0.fm_bram_1_ena && (bif0.fm_bram_1_addra == 7'd10);
    end
    chk("reach_k5", 64'(seen), 1);
    #2;
    en0 = 1'b0;
    wc  = wlog0.size();
    chk("abort_writes_before", 64'(wc - b), 1);
    @(negedge clk);
    chk("abort_ena_off", 64'(bif0.fm_bram_1_ena), 0);
    chk("abort_busy_off", 64'(busy0), 0);
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fin0) nz++;
    end
    chk("abort_no_more_writes", 64'(wlog0.size() - wc), 0);
    chk("abort_no_finish", 64'(nz), 0);
    exp0.delete();
    run_pass(0, 0, b);

    // three-pair instance without ReLU
    run_pass(1, 0, b);
    run_pass(1, 2, b);
    lw = {LANES{16'hFFFB}};
    chk("linear_word0", 64'(wlog1[b] == lw), 1);
    chk("odd_tail_upper_zero", 64'(wlog1[b + 1][W-1:HW] == '0), 1);
    chk("odd_tail_lower", 64'(wlog1[b + 1][HW-1:0] == lw[HW-1:0]), 1);
    run_pass(1, 3, b);
    lw = wlog1[b];
    chk("signed_lane0_linear", 64'(lw[DW-1:0]), 64'h0001);

    repeat (5) @(negedge clk);
    checks += mchecks;
    errors += merrors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
